// File: rtl/ad7606_pkg.sv
// ============================================================================
// ad7606_pkg : shared constants, state encoding and sample packing for the emulator
// Rev 1.0
// ============================================================================
`default_nettype none

package ad7606_pkg;

  localparam int NUM_CH   = 8;
  localparam int CH_ID_W  = 3;
  localparam int FRAME_W  = 13;
  localparam int DB_W     = CH_ID_W + FRAME_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Synthetic sample word: channel id in the top bits, frame number below.
  function automatic logic [DB_W-1:0] make_sample(input logic [CH_ID_W-1:0] id,
                                                  input logic [FRAME_W-1:0] frame);
    return {id, frame};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad7606_emu_if.sv
// ============================================================================
// ad7606_emu_if : parallel-bus pins between the host (master) and the emulated ADC (slave)
// Rev 1.0
// ============================================================================
`default_nettype none

interface ad7606_emu_if;
  import ad7606_pkg::*;

  logic            convst;
  logic            cs_n;
  logic            rd_n;
  logic            busy;
  logic            frstdata;
  logic [DB_W-1:0] db;
  logic            db_oe;
  logic            overrun;

  modport master (
    output convst, cs_n, rd_n,
    input  busy, frstdata, db, db_oe, overrun
  );

  modport slave (
    input  convst, cs_n, rd_n,
    output busy, frstdata, db, db_oe, overrun
  );

endinterface

`default_nettype wire

// File: rtl/ad7606_emu_sync_edge_det.sv
// ============================================================================
// sync_edge_det : 2-flop synchronizer with single-cycle rise/fall pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise =  r_sync & ~r_prev;
  assign o_fall = ~r_sync &  r_prev;

endmodule

`default_nettype wire

// File: rtl/ad7606_emu.sv
// ============================================================================
// ad7606_emu : behavioural AD7606 emulator - convst/busy timing and parallel readout
// Rev 1.0
// ============================================================================
`default_nettype none

module ad7606_emu #(
  parameter int CONV_CYCLES = 200,
  parameter int NUM_CH      = ad7606_pkg::NUM_CH
) (
  input  logic         clk,
  input  logic         rst_n,
  ad7606_emu_if.slave  bus
);
  import ad7606_pkg::*;

  localparam int c_cnt_w = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int c_ptr_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CONV_CYCLES - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(NUM_CH - 1);

  logic w_convst_s, w_convst_rise, w_convst_fall;
  logic w_cs_n_s,   w_cs_rise,     w_cs_fall;
  logic w_rd_s,     w_rd_rise,     w_rd_fall;

  sync_edge_det #(.RST_VAL(1'b0)) u_sync_convst (
    .clk(clk), .rst_n(rst_n), .i_d(bus.convst),
    .o_q(w_convst_s), .o_rise(w_convst_rise), .o_fall(w_convst_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .i_d(bus.cs_n),
    .o_q(w_cs_n_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_sync_rd_n (
    .clk(clk), .rst_n(rst_n), .i_d(bus.rd_n),
    .o_q(w_rd_s), .o_rise(w_rd_rise), .o_fall(w_rd_fall)
  );

  logic w_unused_sync;
  assign w_unused_sync = ^{w_convst_s, w_convst_fall, w_cs_rise, w_cs_fall, w_rd_s, w_rd_rise};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_latch;
  logic                   w_cnt_done;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [FRAME_W-1:0]     r_frame_cnt;
  logic [DB_W-1:0]        r_ch [NUM_CH];
  logic [c_ptr_w-1:0]     r_ptr;
  logic [DB_W-1:0]        r_db;
  logic                   r_frst;
  logic                   r_overrun;
  logic                   w_read;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_cnt_done = (r_cnt == c_cnt_last);
  assign w_read     = w_rd_fall & ~w_cs_n_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A convst rise while in CONV is deliberately not a transition; it only flags overrun.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_convst_rise) w_state_nxt = ST_CONV;
      ST_CONV:  if (w_cnt_done) begin
                  w_state_nxt = ST_READY;
                  w_latch     = 1'b1;
                end
      ST_READY: if (w_convst_rise) w_state_nxt = ST_CONV;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_cnt <= '0;
    else if (r_state != ST_CONV || w_cnt_done) r_cnt <= '0;
    else                                     r_cnt <= r_cnt + c_cnt_w'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) r_ch[k] <= '0;
    end else if (w_latch) begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      for (int k = 0; k < NUM_CH; k++) r_ch[k] <= make_sample(CH_ID_W'(k), r_frame_cnt);
    end
  end

  // A read landing on the latch cycle returns the fresh ch[0], bypassing the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_db   <= '0;
      r_frst <= 1'b0;
    end else begin
      if (w_cs_n_s) begin
        r_db   <= '0;
        r_frst <= 1'b0;
      end else if (w_read) begin
        r_db   <= w_latch ? make_sample('0, r_frame_cnt) : r_ch[r_ptr];
        r_frst <= w_latch | (r_ptr == '0);
      end

      if (w_latch)     r_ptr <= w_read ? f_ptr_inc('0) : '0;
      else if (w_read) r_ptr <= f_ptr_inc(r_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_overrun <= 1'b0;
    else if (w_convst_rise && r_state == ST_CONV) r_overrun <= 1'b1;
  end

  assign bus.busy     = (r_state == ST_CONV);
  assign bus.db_oe    = ~w_cs_n_s;
  assign bus.db       = w_cs_n_s ? '0 : r_db;
  assign bus.frstdata = ~w_cs_n_s & r_frst;
  assign bus.overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_ad7606_emu.sv
// ============================================================================
// tb_ad7606_emu : directed self-checking bench for the AD7606 emulator
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ad7606_emu;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   len;
  int   e;

  ad7606_emu_if bus ();

  ad7606_emu #(.CONV_CYCLES(200), .NUM_CH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench on the first sample where busy is high.
  task automatic convst_pulse(input string tag);
    bus.convst = 1'b1;
    tick(2);
    check({tag, "_busy_pre"}, 32'(bus.busy), 32'd0);
    tick(1);
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    bus.convst = 1'b0;
  endtask

  task automatic measure_busy(input int start, output int n);
    n = start;
    while (bus.busy && n < 1000) begin
      n++;
      tick(1);
    end
  endtask

  task automatic rd_pulse();
    bus.rd_n = 1'b0;
    tick(3);
    bus.rd_n = 1'b1;
    tick(3);
  endtask

  task automatic read_check(input string tag, input logic [15:0] exp_db, input logic exp_frst);
    rd_pulse();
    check({tag, "_db"},   32'(bus.db),       32'(exp_db));
    check({tag, "_frst"}, 32'(bus.frstdata), 32'(exp_frst));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.convst = 1'b0;
    bus.cs_n   = 1'b1;
    bus.rd_n   = 1'b1;
    rst_n      = 1'b0;
    tick(3);
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_db",      32'(bus.db),       32'd0);
    check("rst_db_oe",   32'(bus.db_oe),    32'd0);
    check("rst_frst",    32'(bus.frstdata), 32'd0);
    check("rst_overrun", 32'(bus.overrun),  32'd0);
    rst_n = 1'b1;
    tick(2);

    // Frame 0: latency and length of busy
    convst_pulse("conv0");
    measure_busy(0, len);
    check("conv0_len",     32'(len),         32'd200);
    check("conv0_overrun", 32'(bus.overrun), 32'd0);

    // Full readout of frame 0, then wrap
    bus.cs_n = 1'b0;
    tick(3);
    check("sel_db_oe", 32'(bus.db_oe),    32'd1);
    check("sel_db",    32'(bus.db),       32'd0);
    check("sel_frst",  32'(bus.frstdata), 32'd0);
    for (int k = 0; k < 8; k++)
      read_check($sformatf("f0_rd%0d", k), 16'(k << 13), (k == 0));
    read_check("f0_wrap", 16'h0000, 1'b1);

    // New conversion mid-readout: old frame readable, overrun on second convst
    convst_pulse("conv1");
    read_check("conv1_rd1", 16'h2000, 1'b0);
    read_check("conv1_rd2", 16'h4000, 1'b0);
    check("conv1_overrun_pre", 32'(bus.overrun), 32'd0);
    tick(38);
    bus.convst = 1'b1;
    tick(4);
    bus.convst = 1'b0;
    measure_busy(54, len);
    check("conv1_len",     32'(len),         32'd200);
    check("conv1_overrun", 32'(bus.overrun), 32'd1);
    read_check("f1_rd0", 16'h0001, 1'b1);
    read_check("f1_rd1", 16'h2001, 1'b0);

    // Deselected: outputs quiet, reads ignored
    bus.cs_n = 1'b1;
    tick(3);
    check("desel_db",    32'(bus.db),       32'd0);
    check("desel_db_oe", 32'(bus.db_oe),    32'd0);
    rd_pulse();
    rd_pulse();
    check("desel_rd_db",   32'(bus.db),       32'd0);
    check("desel_rd_frst", 32'(bus.frstdata), 32'd0);
    check("desel_overrun", 32'(bus.overrun),  32'd1);
    bus.cs_n = 1'b0;
    tick(3);
    read_check("resel_rd2", 16'h4001, 1'b0);

    // Reset 100 cycles into busy aborts the conversion
    convst_pulse("conv2");
    tick(99);
    check("conv2_busy_mid", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_overrun", 32'(bus.overrun), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    convst_pulse("conv3");
    measure_busy(0, len);
    check("conv3_len", 32'(len), 32'd200);
    read_check("f0b_rd0", 16'h0000, 1'b1);
    read_check("f0b_rd1", 16'h2000, 1'b0);

    // Read edge coinciding with busy fall returns the new ch[0]
    convst_pulse("conv4");
    tick(197);
    bus.rd_n = 1'b0;
    tick(3);
    check("coinc_busy", 32'(bus.busy),     32'd0);
    check("coinc_db",   32'(bus.db),       32'h0001);
    check("coinc_frst", 32'(bus.frstdata), 32'd1);
    bus.rd_n = 1'b1;
    tick(3);
    read_check("coinc_next", 16'h2001, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
